// File: rtl/serial_sub_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The controller drives through master; the subtractor sits on slave.
interface serial_sub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (output start, a, b, bin, input busy, done, diff, bout, ovf);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout, ovf);
endinterface

// File: rtl/serial_sub.sv
// Bit-serial subtractor: diff = a - b - bin, one full-subtractor cell, LSB first.
// One op takes WIDTH shift cycles plus a one-cycle DONE state.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  serial_sub_if.slave  bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0]    cnt;
  logic             brw, brw_nx, d, last;
  logic             a_msb, b_msb;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q, ovf_q;

  // full-subtractor cell
  assign d      = a_sr[0] ^ b_sr[0] ^ brw;
  assign brw_nx = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = SHIFT;
      SHIFT:   if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_sr  <= bus.a;
          b_sr  <= bus.b;
          brw   <= bus.bin;
          cnt   <= '0;
          a_msb <= bus.a[WIDTH-1];
          b_msb <= bus.b[WIDTH-1];
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= {d, res[WIDTH-1:1]};
          brw  <= brw_nx;
          if (!last) cnt <= cnt + CW'(1);
          // results are published only on completion so they hold through later ops
          if (last) begin
            diff_q <= {d, res[WIDTH-1:1]};
            bout_q <= brw_nx;
            ovf_q  <= (a_msb ^ b_msb) & (d ^ a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_serial_sub.sv
// Scoreboard bench for serial_sub: driver pushes arithmetic expectations with
// their due cycle; a negedge monitor checks done timing, results, busy and hold.
module tb_serial_sub;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  bit   in_reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t held;

  serial_sub_if #(.WIDTH(W)) bus ();

  serial_sub #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input int unsigned a, input int unsigned b,
                                 input int unsigned bi, input int due);
    exp_t e;
    int   r, sa, sb, sd;
    r  = int'(a) - int'(b) - int'(bi);
    sa = (a >= 2**(W-1)) ? int'(a) - 2**W : int'(a);
    sb = (b >= 2**(W-1)) ? int'(b) - 2**W : int'(b);
    sd = sa - sb - int'(bi);
    e.diff = r[W-1:0];
    e.bout = (r < 0);
    e.ovf  = (sd < -(2**(W-1))) || (sd > 2**(W-1) - 1);
    e.cyc  = due;
    return e;
  endfunction

  // Call just after a rising edge when the DUT will be idle at the next edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bi;
    q.push_back(model(a, b, bi, cyc + 1 + W));
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    @(posedge clk); #1;
    issue(a, b, bi);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    bus.bin   = 1'($urandom);
    repeat (W + 1 + $urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset    = 1'b1;
    in_reset = 1'b1;
    q.delete();
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    held      = '{default: 0};
    in_reset  = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!in_reset) begin
      chk("busy", bus.busy, (q.size() > 0 && cyc >= q[0].cyc - W) ? 1 : 0);
      if (bus.done) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          held = q.pop_front();
          chk("done_cycle", cyc, held.cyc);
          chk("diff", bus.diff, held.diff);
          chk("bout", bus.bout, held.bout);
          chk("ovf",  bus.ovf,  held.ovf);
        end
      end else begin
        if (q.size() > 0 && cyc >= q[0].cyc) begin
          chk("missing_done", 0, 1);
          held = q.pop_front();
        end else begin
          chk("hold_diff", bus.diff, held.diff);
          chk("hold_bout", bus.bout, held.bout);
          chk("hold_ovf",  bus.ovf,  held.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_reset  = 1'b1;
    held      = '{default: 0};
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    in_reset = 1'b0;

    // directed vectors
    do_op(8'h35, 8'h12, 1'b0);
    do_op(8'h12, 8'h35, 1'b0);
    do_op(8'h80, 8'h01, 1'b0);
    do_op(8'h7F, 8'hFF, 1'b0);
    do_op(8'h00, 8'h00, 1'b1);
    do_op(8'hFF, 8'hFF, 1'b0);
    do_op(8'hA5, 8'hA5, 1'b0);
    do_op(8'h5A, 8'h5A, 1'b1);
    do_op(8'hFF, 8'h00, 1'b1);
    do_op(8'h00, 8'hFF, 1'b1);

    // start held high throughout an op; only the first and the post-done one count
    @(posedge clk); #1;
    issue(8'h10, 8'h01, 1'b0);
    for (int j = 1; j <= W + 2; j++) begin
      @(posedge clk); #1;
      if (j == W + 2) issue(W'($urandom), W'($urandom), 1'($urandom));
      else begin
        bus.a   = W'($urandom);
        bus.b   = W'($urandom);
        bus.bin = 1'($urandom);
      end
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (W + 2) @(posedge clk);

    // reset in the middle of a shift (count==4 when reset is sampled)
    @(posedge clk); #1;
    issue(8'h44, 8'h21, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    do_reset();
    repeat (W + 3) @(posedge clk);
    do_op(8'h44, 8'h21, 1'b0);

    for (int i = 0; i < 40; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom));

    repeat (W + 4) @(posedge clk);
    chk("pending_at_end", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
